// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pll_reset_sequencer
//  Purpose  : Drives a PLL reset pulse, waits for lock (with timeout and
//             bounded retries), requires a run of stable lock before releasing
//             the downstream reset, and re-sequences on lock loss or restart.
//  Ports    : refclk_i   - sole clock, rising edge
//             rst_i      - synchronous active-high reset
//             locked_i   - PLL lock, asynchronous to refclk_i
//             restart_i  - single-cycle request to re-run the sequence
//             pll_rst_o  - PLL reset (PULSE and FAIL)
//             sys_rst_o  - downstream reset (low only in RUN)
//             ready_o    - high only in RUN
//             fail_o     - high only in FAIL
//             state_o    - PULSE=0, WAIT=1, STABLE=2, RUN=3, FAIL=4
//             loss_cnt_o - saturating count of lock losses seen in RUN
//  Config   : PLL_SEQ_LOSS_CNT_EN - when defined, loss_cnt_o is a live counter;
//             otherwise it is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 50000,
    parameter int STABLE_CYCLES    = 1024,
    parameter int MAX_RETRIES      = 4
) (
    input  logic       refclk_i,
    input  logic       rst_i,
    input  logic       locked_i,
    input  logic       restart_i,
    output logic       pll_rst_o,
    output logic       sys_rst_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [2:0] state_o,
    output logic [7:0] loss_cnt_o
);

    typedef enum logic [2:0] {
        ST_PULSE  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    // Terminal values: the counter starts at 0 on entry, so phase N ends
    // when the counter holds N-1.
    localparam logic [15:0] C_PULSE_LAST   = 16'(RST_PULSE_CYCLES - 1);
    localparam logic [15:0] C_TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] C_STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [3:0]  C_RETRY_LAST   = 4'(MAX_RETRIES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic [1:0]  sync_q;
    logic        lock_s;
    logic        pll_rst_q, sys_rst_q, ready_q, fail_q;

    // Two-flop synchronizer; left unreset so it always tracks locked_i.
    always_ff @(posedge refclk_i) begin
        sync_q <= {sync_q[0], locked_i};
    end
    assign lock_s = sync_q[1];

    // Next-state logic. Counters are bounded by their terminal compares
    // and so never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (restart_i) begin
            state_d = ST_PULSE;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_PULSE: begin
                    if (cnt_q == C_PULSE_LAST) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_WAIT: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == C_TIMEOUT_LAST) begin
                        cnt_d   = '0;
                        retry_d = retry_q + 4'd1;
                        state_d = (retry_q == C_RETRY_LAST) ? ST_FAIL : ST_PULSE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == C_STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_PULSE;
                        cnt_d   = '0;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // State register; outputs are decoded from the next state so that they
    // are registered yet change in the same cycle as the state.
    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            state_q   <= ST_PULSE;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == ST_PULSE) || (state_d == ST_FAIL);
            sys_rst_q <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_RUN);
            fail_q    <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst_o = pll_rst_q;
    assign sys_rst_o = sys_rst_q;
    assign ready_o   = ready_q;
    assign fail_o    = fail_q;
    assign state_o   = state_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    // A loss is counted whenever RUN sees lock drop, even if restart is
    // requested in the same cycle; rst alone clears the count.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if ((state_q == ST_RUN) && !lock_s && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt_o = loss_cnt_q;
`else
    assign loss_cnt_o = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pll_reset_sequencer
//  Purpose  : Directed self-checking bench for pll_reset_sequencer with a
//             phase/elapsed-time reference model compared every cycle, plus
//             literal expectations at hand-computed cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int RST_PULSE_CYCLES = 4;
    localparam int LOCK_TIMEOUT     = 20;
    localparam int STABLE_CYCLES    = 8;
    localparam int MAX_RETRIES      = 2;
`ifdef PLL_SEQ_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    localparam int P_PULSE = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, sys_rst, ready, fail;
    logic [2:0] state;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES (RST_PULSE_CYCLES),
        .LOCK_TIMEOUT     (LOCK_TIMEOUT),
        .STABLE_CYCLES    (STABLE_CYCLES),
        .MAX_RETRIES      (MAX_RETRIES)
    ) dut (
        .refclk_i   (clk),
        .rst_i      (rst),
        .locked_i   (locked),
        .restart_i  (restart),
        .pll_rst_o  (pll_rst),
        .sys_rst_o  (sys_rst),
        .ready_o    (ready),
        .fail_o     (fail),
        .state_o    (state),
        .loss_cnt_o (loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase plus number of cycles already spent in it; lock seen by the
    // sequencer is locked as sampled two edges earlier.
    int m_phase    = P_PULSE;
    int m_elapsed  = 0;
    int m_timeouts = 0;
    int m_loss     = 0;
    bit m_hist0    = 1'b0;
    bit m_hist1    = 1'b0;

    task automatic model_step();
        bit ls;
        ls      = m_hist1;
        m_hist1 = m_hist0;
        m_hist0 = locked;
        if (rst) begin
            m_phase = P_PULSE; m_elapsed = 0; m_timeouts = 0; m_loss = 0;
        end else begin
            if (LOSS_EN && m_phase == P_RUN && !ls && m_loss < 255) m_loss++;
            if (restart) begin
                m_phase = P_PULSE; m_elapsed = 0; m_timeouts = 0;
            end else begin
                case (m_phase)
                    P_PULSE: begin
                        m_elapsed++;
                        if (m_elapsed == RST_PULSE_CYCLES) begin
                            m_phase = P_WAIT; m_elapsed = 0;
                        end
                    end
                    P_WAIT: begin
                        if (ls) begin
                            m_phase = P_STABLE; m_elapsed = 0;
                        end else begin
                            m_elapsed++;
                            if (m_elapsed == LOCK_TIMEOUT) begin
                                m_timeouts++;
                                m_elapsed = 0;
                                m_phase = (m_timeouts == MAX_RETRIES) ? P_FAIL : P_PULSE;
                            end
                        end
                    end
                    P_STABLE: begin
                        if (!ls) begin
                            m_phase = P_WAIT; m_elapsed = 0;
                        end else begin
                            m_elapsed++;
                            if (m_elapsed == STABLE_CYCLES) begin
                                m_phase = P_RUN; m_timeouts = 0;
                            end
                        end
                    end
                    P_RUN: begin
                        if (!ls) begin
                            m_phase = P_PULSE; m_elapsed = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("model_state",   int'(state),    m_phase);
            chk("model_pll_rst", int'(pll_rst),  int'(m_phase == P_PULSE || m_phase == P_FAIL));
            chk("model_sys_rst", int'(sys_rst),  int'(m_phase != P_RUN));
            chk("model_ready",   int'(ready),    int'(m_phase == P_RUN));
            chk("model_fail",    int'(fail),     int'(m_phase == P_FAIL));
            chk("model_loss",    int'(loss_cnt), m_loss);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (state != 3'd3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_run", int'(state), 3);
    endtask

    // One-cycle lock glitch while in RUN; returns at mid-cycle c+3 (PULSE).
    task automatic glitch();
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(2);
    endtask

    initial begin
        tick(3);
        rst = 1'b0;                 // mid cycle 1
        chk("c1_state", int'(state), 0);
        chk("c1_pll_rst", int'(pll_rst), 1);
        tick(3);                    // cycle 4
        chk("c4_pll_rst", int'(pll_rst), 1);
        tick(1);                    // cycle 5
        chk("c5_state", int'(state), 1);
        chk("c5_pll_rst", int'(pll_rst), 0);
        tick(1);                    // cycle 6
        locked = 1'b1;
        tick(2);                    // cycle 8
        chk("c8_state", int'(state), 1);
        tick(1);                    // cycle 9
        chk("c9_state", int'(state), 2);
        tick(7);                    // cycle 16
        chk("c16_state", int'(state), 2);
        chk("c16_sys_rst", int'(sys_rst), 1);
        tick(1);                    // cycle 17
        chk("c17_state", int'(state), 3);
        chk("c17_sys_rst", int'(sys_rst), 0);
        chk("c17_ready", int'(ready), 1);

        // Lock glitch in RUN
        glitch();
        chk("gl_sys_rst", int'(sys_rst), 1);
        chk("gl_ready", int'(ready), 0);
        chk("gl_loss", int'(loss_cnt), LOSS_EN ? 1 : 0);
        wait_run();

        // Lock drop in STABLE after 5 counted cycles
        restart = 1'b1;             // mid r
        tick(1);
        restart = 1'b0;             // r+1
        chk("rs_state", int'(state), 0);
        chk("rs_loss", int'(loss_cnt), LOSS_EN ? 1 : 0);
        tick(8);                    // r+9
        locked = 1'b0;
        tick(3);                    // r+12
        locked = 1'b1;
        chk("st_drop_state", int'(state), 1);
        tick(8);                    // r+20
        chk("st_fresh_state", int'(state), 2);
        tick(3);                    // r+23
        chk("st_run_state", int'(state), 3);

        // Saturating loss counter
        repeat (300) begin
            glitch();
            wait_run();
        end
        chk("sat_loss", int'(loss_cnt), LOSS_EN ? 255 : 0);

        // rst mid-STABLE, together with restart
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(7);                    // in STABLE
        chk("pre_rst_state", int'(state), 2);
        rst = 1'b1;
        restart = 1'b1;
        tick(1);
        rst = 1'b0;
        restart = 1'b0;
        chk("rst_state", int'(state), 0);
        chk("rst_loss", int'(loss_cnt), 0);
        chk("rst_pll_rst", int'(pll_rst), 1);
        wait_run();

        // restart together with lock loss in RUN
        locked = 1'b0;
        tick(2);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        locked = 1'b1;
        chk("rl_state", int'(state), 0);
        chk("rl_loss", int'(loss_cnt), LOSS_EN ? 1 : 0);
        wait_run();

        // Lock never arrives: two timeouts then FAIL
        restart = 1'b1;
        locked = 1'b0;              // mid r
        tick(1);
        restart = 1'b0;
        tick(23);                   // r+24
        chk("to1_state", int'(state), 1);
        tick(1);                    // r+25
        chk("to1_pulse", int'(state), 0);
        chk("to1_pll_rst", int'(pll_rst), 1);
        tick(23);                   // r+48
        chk("to2_state", int'(state), 1);
        tick(1);                    // r+49
        chk("fail_state", int'(state), 4);
        chk("fail_flag", int'(fail), 1);
        chk("fail_pll_rst", int'(pll_rst), 1);
        tick(30);
        chk("fail_hold", int'(state), 4);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("fr_state", int'(state), 0);
        chk("fr_fail", int'(fail), 0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog at %0t: actual=timeout required=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
